decoder3_scan_seq: RTL and testbench

Scan sequencer that sits directly upstream of the 3-to-8 decoder (`decoder3`). It drives the decoder's enable and 3-bit select so that each unmasked output line is asserted in turn for a programmable number of cycles. Between addresses it inserts a blanking gap, with enable low while select changes, so no decoder output glitches. It supports single-pass and continuous scans, a skip mask, abort, and done/wrap status for the controlling logic.

---
 rtl/decoder3_scan_seq_pkg.sv | 14 +
 rtl/decoder3_scan_seq_if.sv | 28 ++
 rtl/decoder3_next_addr.sv | 25 ++
 rtl/decoder3_scan_seq.sv | 167 ++++++++++++++++
 tb/tb_decoder3_scan_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/decoder3_scan_seq_pkg.sv
// Shared widths and FSM encoding for the decoder3 scan sequencer.
// Pure declarations; no logic, no latency.
package decoder3_scan_seq_pkg;

    localparam int ADDR_W    = 3;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/decoder3_scan_seq_if.sv
// Control/status bundle between a scan controller and the sequencer.
// master = controlling logic, slave = the sequencer itself.
interface decoder3_scan_seq_if
    import decoder3_scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8
);
    logic                 start;
    logic                 stop;
    logic                 mode;
    logic [NUM_LINES-1:0] mask;
    logic [DWELL_W-1:0]   dwell;
    logic                 en;
    logic [ADDR_W-1:0]    sel;
    logic                 busy;
    logic                 done;
    logic                 wrap;

    modport master (
        output start, stop, mode, mask, dwell,
        input  en, sel, busy, done, wrap
    );

    modport slave (
        input  start, stop, mode, mask, dwell,
        output en, sel, busy, done, wrap
    );
endinterface

// File: rtl/decoder3_next_addr.sv
// Lowest unmasked line, overall or strictly above cur.
// Purely combinational, no state.
module decoder3_next_addr
    import decoder3_scan_seq_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [ADDR_W-1:0]    cur,
    input  logic                 from_start,
    output logic [ADDR_W-1:0]    nxt,
    output logic                 valid
);

    // Descending walk so the lowest qualifying index is the last one written.
    always_comb begin
        nxt   = '0;
        valid = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!mask[i] && (from_start || (i > int'(cur)))) begin
                nxt   = ADDR_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder3_scan_seq.sv
// Steps decoder3 enable/select over unmasked lines with a blanking gap between addresses.
// All outputs registered; start->busy one edge, en rises BLANK edges later.
module decoder3_scan_seq
    import decoder3_scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int BLANK   = 1
)(
    input  logic               clk,
    input  logic               rst,
    decoder3_scan_seq_if.slave bus
);

    localparam logic [3:0] BLANK_LD = 4'(BLANK - 1);

    state_t               state_q, state_n;
    logic                 en_q, en_n;
    logic [ADDR_W-1:0]    sel_q, sel_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 wrap_q, wrap_n;
    logic [3:0]           bcnt_q, bcnt_n;
    logic [DWELL_W-1:0]   dcnt_q, dcnt_n;
    logic                 mode_q, mode_n;
    logic [NUM_LINES-1:0] mask_q, mask_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;

    logic [NUM_LINES-1:0] first_mask;
    logic [ADDR_W-1:0]    first_addr, up_addr;
    logic                 first_vld, up_vld;
    logic [DWELL_W-1:0]   dwell_ld;

    // In IDLE the config is being latched this very edge, so look at the live mask.
    assign first_mask = (state_q == ST_IDLE) ? bus.mask : mask_q;
    assign dwell_ld   = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    decoder3_next_addr u_first (
        .mask       (first_mask),
        .cur        (sel_q),
        .from_start (1'b1),
        .nxt        (first_addr),
        .valid      (first_vld)
    );

    decoder3_next_addr u_up (
        .mask       (mask_q),
        .cur        (sel_q),
        .from_start (1'b0),
        .nxt        (up_addr),
        .valid      (up_vld)
    );

    always_comb begin
        state_n = state_q;
        en_n    = en_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        bcnt_n  = bcnt_q;
        dcnt_n  = dcnt_q;
        mode_n  = mode_q;
        mask_n  = mask_q;
        dwell_n = dwell_q;

        case (state_q)
            ST_IDLE: begin
                en_n   = 1'b0;
                busy_n = 1'b0;
                if (bus.start && !bus.stop) begin
                    mode_n  = bus.mode;
                    mask_n  = bus.mask;
                    dwell_n = bus.dwell;
                    if (first_vld) begin
                        state_n = ST_BLANK;
                        sel_n   = first_addr;
                        busy_n  = 1'b1;
                        bcnt_n  = BLANK_LD;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            ST_BLANK: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end else if (bcnt_q == '0) begin
                    state_n = ST_DRIVE;
                    en_n    = 1'b1;
                    dcnt_n  = dwell_ld;
                end else begin
                    bcnt_n = bcnt_q - 4'd1;
                end
            end

            ST_DRIVE: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end else if (dcnt_q == '0) begin
                    en_n = 1'b0;
                    if (up_vld) begin
                        state_n = ST_BLANK;
                        sel_n   = up_addr;
                        bcnt_n  = BLANK_LD;
                    end else if (mode_q) begin
                        state_n = ST_BLANK;
                        sel_n   = first_addr;
                        bcnt_n  = BLANK_LD;
                        wrap_n  = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt_q - DWELL_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            bcnt_q  <= '0;
            dcnt_q  <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_n;
            en_q    <= en_n;
            sel_q   <= sel_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            wrap_q  <= wrap_n;
            bcnt_q  <= bcnt_n;
            dcnt_q  <= dcnt_n;
            mode_q  <= mode_n;
            mask_q  <= mask_n;
            dwell_q <= dwell_n;
        end
    end

    assign bus.en   = en_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder3_scan_seq.sv
// Scoreboard bench: a scan-level model pushes the expected per-cycle outputs,
// a negedge monitor pops and compares; an empty queue means the block must sit idle.
module tb_decoder3_scan_seq;

    localparam int DWELL_W = 8;
    localparam int BLANK   = 1;

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
        logic       busy;
        logic       done;
        logic       wrap;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder3_scan_seq_if #(.DWELL_W(DWELL_W)) bus ();

    decoder3_scan_seq #(.DWELL_W(DWELL_W), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t       exp_q[$];
    logic [2:0] model_sel = 3'd0;
    logic [2:0] idle_sel  = 3'd0;
    bit         mon_on    = 1'b0;
    int         vectors   = 0;
    int         miscompares = 0;

    function automatic obs_t mk_obs(bit en, int sel, bit busy, bit done, bit wrap);
        obs_t o;
        o.en = en; o.sel = 3'(sel); o.busy = busy; o.done = done; o.wrap = wrap;
        return o;
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got en=%b sel=%0d busy=%b done=%b wrap=%b, want en=%b sel=%0d busy=%b done=%b wrap=%b",
                     name, $time, act.en, act.sel, act.busy, act.done, act.wrap,
                     exp.en, exp.sel, exp.busy, exp.done, exp.wrap);
        end
    endtask

    function automatic obs_t sample();
        return mk_obs(bus.en, int'(bus.sel), bus.busy, bus.done, bus.wrap);
    endfunction

    // Monitor: every cycle is an output; queued entries first, otherwise idle.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (!rst && mon_on) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = mk_obs(0, int'(idle_sel), 0, 0, 0);
                idle_sel = e.sel;
                check("cycle_obs", sample(), e);
            end
        end
    end

    // Scan-level model: list unmasked lines, emit BLANK gap + D drive cycles each.
    task automatic model_push(input bit m, input logic [7:0] mk, input int dw,
                              input int limit, output int len);
        int addrs[$];
        int d;
        int pass;
        len = 0;
        d   = (dw == 0) ? 1 : dw;
        for (int i = 0; i < 8; i++) if (!mk[i]) addrs.push_back(i);
        if (addrs.size() == 0) begin
            exp_q.push_back(mk_obs(0, int'(model_sel), 0, 1, 0));
            len = 1;
            return;
        end
        pass = 0;
        while (pass < 64) begin
            foreach (addrs[k]) begin
                model_sel = 3'(addrs[k]);
                for (int b = 0; b < BLANK; b++) begin
                    exp_q.push_back(mk_obs(0, addrs[k], 1, 0, (pass > 0 && k == 0 && b == 0)));
                    len++;
                    if (limit > 0 && len >= limit) return;
                end
                for (int c = 0; c < d; c++) begin
                    exp_q.push_back(mk_obs(1, addrs[k], 1, 0, 0));
                    len++;
                    if (limit > 0 && len >= limit) return;
                end
            end
            if (!m) begin
                exp_q.push_back(mk_obs(0, int'(model_sel), 0, 1, 0));
                len++;
                return;
            end
            pass++;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 4000 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // limit>0 asserts stop so that exactly `limit` scan cycles are observed.
    task automatic run_scan(input bit m, input logic [7:0] mk, input int dw,
                            input int limit, input bit interfere);
        int len;
        @(posedge clk); #1;
        bus.mode = m; bus.mask = mk; bus.dwell = 8'(dw); bus.start = 1'b1; bus.stop = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_push(m, mk, dw, limit, len);
        for (int s = 1; s < len; s++) begin
            if (interfere) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.mode  = 1'($urandom_range(0, 1));
                bus.mask  = 8'($urandom);
                bus.dwell = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        if (limit > 0) begin
            bus.stop  = 1'b1;
            bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            bus.stop = 1'b0;
        end
        bus.start = 1'b0;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, dw, lim, r;
        bit         m;
        logic [7:0] mk;

        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.mask  = 8'h00; bus.dwell = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), mk_obs(0, 0, 0, 0, 0));
        rst = 1'b0;
        mon_on = 1'b1;

        // Full sweep with interference (start re-pulses, dwell/mask changes mid-scan).
        run_scan(0, 8'h00, 2, 0, 1);
        run_scan(0, 8'b1010_1010, 0, 0, 0);
        run_scan(0, 8'hFF, 1, 0, 0);
        // Continuous single line: three passes plus the first wrap cycle, then stop.
        run_scan(1, 8'hFE, 3, 13, 0);

        // Async reset mid-DRIVE.
        @(posedge clk); #1;
        bus.mode = 1'b0; bus.mask = 8'h00; bus.dwell = 8'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_push(0, 8'h00, 2, 0, n);
        repeat (BLANK) @(posedge clk);
        #2;
        check("pre_reset_drive", sample(), mk_obs(1, 0, 1, 0, 0));
        rst = 1'b1;
        #1;
        check("reset_mid_drive", sample(), mk_obs(0, 0, 0, 0, 0));
        exp_q.delete();
        model_sel = 3'd0;
        idle_sel  = 3'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // start and stop together while idle: nothing may begin.
        #1;
        bus.mask = 8'h00; bus.dwell = 8'd1; bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        repeat (4) @(posedge clk);

        for (int it = 0; it < 40; it++) begin
            m  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 7));
            if (r == 0)      mk = 8'hFF;
            else if (r == 1) mk = ~(8'h01 << $urandom_range(0, 7));
            else             mk = 8'($urandom);
            dw = int'($urandom_range(0, 4));
            n  = 0;
            for (int i = 0; i < 8; i++) if (!mk[i]) n++;
            lim = 0;
            if (n > 0 && m) lim = int'($urandom_range(1, 30));
            else if (n > 0 && $urandom_range(0, 3) == 0)
                lim = int'($urandom_range(1, n * (BLANK + ((dw == 0) ? 1 : dw))));
            run_scan(m, mk, dw, lim, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
